// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer family: select-mode encodings
// and channel-index width helper.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ... modulo NUM_CH and
// returns the first requesting channel.
module rr_picker
    import mux_pkg::*;
#(
    parameter  int NUM_CH    = 8,
    localparam int SEL_WIDTH = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0]    req,
    input  logic [SEL_WIDTH-1:0] ptr,
    output logic [SEL_WIDTH-1:0] grant,
    output logic                 grant_valid
);

    // Priority scan starting just after the last winner; the index never leaves 0..NUM_CH-1.
    always_comb begin
        int   idx;
        logic hit;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        hit         = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx         = (int'(ptr) + off) % NUM_CH;
            hit         = !grant_valid && req[idx];
            grant       = hit ? SEL_WIDTH'(idx) : grant;
            grant_valid = grant_valid | hit;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel stream multiplexer with a one-entry registered output stage,
// direct or round-robin channel selection and valid/ready on every channel.
module arb_mux
    import mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 8,
    localparam int SEL_WIDTH  = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]            in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_ch
);

    logic [SEL_WIDTH-1:0]      ptr_r;
    logic [SEL_WIDTH-1:0]      rr_grant_s;
    logic                      rr_valid_s;
    logic [SEL_WIDTH-1:0]      grant_s;
    logic                      grant_valid_s;
    logic                      load_s;
    logic [(2**SEL_WIDTH)-1:0] valid_pad_s;
    logic [DATA_WIDTH-1:0]     sel_data_s;

    rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_rr_picker (
        .req         (in_valid),
        .ptr         (ptr_r),
        .grant       (rr_grant_s),
        .grant_valid (rr_valid_s)
    );

    // Grant selection; padding in_valid makes any out-of-range sel read as no request.
    always_comb begin
        valid_pad_s               = '0;
        valid_pad_s[NUM_CH-1:0]   = in_valid;
        if (mode == MODE_RR) begin
            grant_s       = rr_grant_s;
            grant_valid_s = rr_valid_s;
        end else begin
            grant_s       = sel;
            grant_valid_s = valid_pad_s[sel];
        end
    end

    // Handshake: accept only when the stage is free or draining, and never during reset.
    always_comb begin
        load_s     = reset && (!out_valid || out_ready) && grant_valid_s;
        sel_data_s = in_data[grant_s*DATA_WIDTH +: DATA_WIDTH];
        if (load_s) begin
            in_ready = NUM_CH'(1'b1) << grant_s;
        end else begin
            in_ready = '0;
        end
    end

    // Output register: load replaces the beat, drain without load empties the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_s) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_s;
            out_ch    <= grant_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Round-robin pointer follows round-robin winners only; reset gives channel 0 first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= SEL_WIDTH'(NUM_CH - 1);
        end else if (load_s && (mode == MODE_RR)) begin
            ptr_r <= grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: an 8-channel instance checked against a cycle
// model, plus a 6-channel instance for the non-power-of-two boundaries.
module tb_arb_mux;

    logic         clk;
    logic         reset;

    logic         mode8, ordy8, ov8;
    logic [2:0]   sel8, oc8;
    logic [7:0]   iv8, ir8;
    logic [255:0] id8;
    logic [31:0]  od8;

    logic         mode6, ordy6, ov6;
    logic [2:0]   sel6, oc6;
    logic [5:0]   iv6, ir6;
    logic [191:0] id6;
    logic [31:0]  od6;

    int           n_checks = 0;
    int           n_pass   = 0;

    bit           m_valid;
    int           m_ptr;
    int           q_ch[$];
    logic [31:0]  q_data[$];

    arb_mux #(.DATA_WIDTH(32), .NUM_CH(8)) u_dut8 (
        .clk(clk), .reset(reset), .mode(mode8), .sel(sel8),
        .in_valid(iv8), .in_data(id8), .in_ready(ir8),
        .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_ch(oc8)
    );

    arb_mux #(.DATA_WIDTH(32), .NUM_CH(6)) u_dut6 (
        .clk(clk), .reset(reset), .mode(mode6), .sel(sel6),
        .in_valid(iv6), .in_data(id6), .in_ready(ir6),
        .out_valid(ov6), .out_ready(ordy6), .out_data(od6), .out_ch(oc6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference grant for the 8-channel instance.
    task automatic model_grant(output int g, output bit gv);
        int k;
        g  = 0;
        gv = 1'b0;
        if (mode8 == 1'b0) begin
            if (iv8[sel8]) begin
                g  = int'(sel8);
                gv = 1'b1;
            end
        end else begin
            k = m_ptr;
            repeat (8) begin
                k = (k + 1) % 8;
                if (!gv && iv8[k]) begin
                    g  = k;
                    gv = 1'b1;
                end
            end
        end
    endtask

    // One clock of the 8-channel instance: check at negedge, advance model, step past posedge.
    task automatic cycle8();
        int         g;
        bit         gv;
        bit         load;
        logic [7:0] exp_ir;
        @(negedge clk);
        model_grant(g, gv);
        load   = (!m_valid || ordy8) && gv;
        exp_ir = load ? (8'd1 << g) : 8'd0;
        check("in_ready8", 64'(ir8), 64'(exp_ir));
        check("out_valid8", 64'(ov8), 64'(m_valid));
        if (m_valid) begin
            if (q_ch.size() == 0) begin
                check("sb_depth", 64'(q_ch.size()), 64'd1);
            end else begin
                check("out_ch8", 64'(oc8), 64'(q_ch[0]));
                check("out_data8", 64'(od8), 64'(q_data[0]));
                if (ordy8) begin
                    void'(q_ch.pop_front());
                    void'(q_data.pop_front());
                end
            end
        end
        if (load) begin
            q_ch.push_back(g);
            q_data.push_back(id8[g*32 +: 32]);
            m_valid = 1'b1;
            if (mode8) m_ptr = g;
        end else if (ordy8) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_ptr   = 7;
        q_ch.delete();
        q_data.delete();
        repeat (cycles) begin
            @(negedge clk);
            check("rst_out_valid", 64'(ov8), 64'd0);
            check("rst_out_data", 64'(od8), 64'd0);
            check("rst_out_ch", 64'(oc8), 64'd0);
            check("rst_in_ready", 64'(ir8), 64'd0);
            check("rst_in_ready6", 64'(ir6), 64'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        mode8 = 1'b0; sel8 = 3'd0; iv8 = 8'hFF; ordy8 = 1'b1;
        mode6 = 1'b0; sel6 = 3'd0; iv6 = 6'h3F; ordy6 = 1'b1;
        for (int i = 0; i < 8; i++) id8[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 6; i++) id6[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        @(posedge clk);
        #1;

        // Reset with requests pending, then idle.
        do_reset(3);
        iv8 = 8'h00; iv6 = 6'h00;
        repeat (3) cycle8();

        // Direct select of channel 5.
        mode8 = 1'b0; sel8 = 3'd5; iv8 = 8'hFF; ordy8 = 1'b1;
        repeat (4) cycle8();
        check("direct_out_data", 64'(od8), 64'h0000_0000_A000_0005);

        // Round-robin fairness from reset: 0..7,0..7 with no bubbles.
        do_reset(1);
        mode8 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle8();
            check("rr_no_bubble", 64'(ov8), 64'd1);
            check("rr_sequence", 64'(oc8), 64'(k % 8));
        end
        iv8 = 8'h00;
        cycle8();

        // Back-pressure with channel 2 held.
        mode8 = 1'b0; sel8 = 3'd2; iv8 = 8'hFF;
        id8[2*32 +: 32] = 32'h1234_5678;
        cycle8();
        ordy8 = 1'b0; sel8 = 3'd6;
        repeat (4) cycle8();
        check("bp_held_data", 64'(od8), 64'h0000_0000_1234_5678);
        ordy8 = 1'b1;
        cycle8();
        check("bp_reload_ch", 64'(oc8), 64'd6);
        cycle8();

        // Mid-operation reset with a held beat.
        mode8 = 1'b1;
        repeat (3) cycle8();
        ordy8 = 1'b0;
        cycle8();
        check("pre_rst_valid", 64'(ov8), 64'd1);
        #2;
        reset = 1'b0;
        ordy8 = 1'b1;
        #1;
        check("async_rst_valid", 64'(ov8), 64'd0);
        check("async_rst_ready", 64'(ir8), 64'd0);
        do_reset(2);
        cycle8();
        check("post_rst_rr_ch", 64'(oc8), 64'd0);
        iv8 = 8'h00;
        cycle8();

        // Six-channel boundaries: out-of-range sel, and scan wrap from ptr=5.
        mode6 = 1'b0; sel6 = 3'd7; iv6 = 6'h3F; ordy6 = 1'b1;
        @(negedge clk);
        check("n6_sel7_ready", 64'(ir6), 64'd0);
        @(posedge clk); #1;
        sel6 = 3'd6;
        @(negedge clk);
        check("n6_sel7_valid", 64'(ov6), 64'd0);
        check("n6_sel6_ready", 64'(ir6), 64'd0);
        @(posedge clk); #1;
        mode6 = 1'b1; iv6 = 6'b100000;
        @(negedge clk);
        check("n6_sel6_valid", 64'(ov6), 64'd0);
        check("n6_rr_ready5", 64'(ir6), 64'b100000);
        @(posedge clk); #1;
        iv6 = 6'b000001;
        @(negedge clk);
        check("n6_load5_ch", 64'(oc6), 64'd5);
        check("n6_load5_data", 64'(od6), 64'h0000_0000_B000_0005);
        check("n6_wrap_ready", 64'(ir6), 64'b000001);
        @(posedge clk); #1;
        iv6 = 6'b000000;
        @(negedge clk);
        check("n6_wrap_ch", 64'(oc6), 64'd0);
        check("n6_wrap_data", 64'(od6), 64'h0000_0000_B000_0000);
        check("n6_wrap_valid", 64'(ov6), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
